// File: rtl/pkg_memorymap.sv
// Host address map of the NPU: start/end byte address of every decoded region.
package pkg_memorymap;

  localparam logic [31:0] IMEM_Start = 32'h0000_0000;
  localparam logic [31:0] IMEM_End   = 32'h0000_03FF;
  localparam logic [31:0] WMEM_Start = 32'h0000_1000;
  localparam logic [31:0] WMEM_End   = 32'h0000_13FF;
  localparam logic [31:0] BMEM_Start = 32'h0000_2000;
  localparam logic [31:0] BMEM_End   = 32'h0000_23FF;
  localparam logic [31:0] OMEM_Start = 32'h0000_3000;
  localparam logic [31:0] OMEM_End   = 32'h0000_33FF;
  localparam logic [31:0] PARA_Start = 32'h0000_4000;
  localparam logic [31:0] PARA_End   = 32'h0000_4007;

endpackage

// File: rtl/pkg_npu.sv
// Shared types of the NPU command dispatcher: decoder op codes, FSM states
// and the op -> region base lookup.
package pkg_npu;
  import pkg_memorymap::*;

  typedef enum logic [3:0] {
    OP_NONE     = 4'b0000,
    OP_MOVE     = 4'b0001,
    OP_IMEM     = 4'b1000,
    OP_WMEM     = 4'b1001,
    OP_BMEM     = 4'b1010,
    OP_OMEM     = 4'b1011,
    OP_PARA     = 4'b1100,
    OP_OS_START = 4'b1111
  } npu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    MOVE  = 2'd2,
    DRAIN = 2'd3
  } disp_state_e;

  function automatic logic [31:0] region_base(input npu_op_e op);
    case (op)
      OP_IMEM: return IMEM_Start;
      OP_WMEM: return WMEM_Start;
      OP_BMEM: return BMEM_Start;
      OP_OMEM: return OMEM_Start;
      OP_PARA: return PARA_Start;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/npu_move_engine.sv
// OMEM -> IMEM copy engine: read counter plus a one-stage read->write pipeline
// so one word moves per cycle while the FSM holds MOVE, the last write in DRAIN.
module npu_move_engine #(
  parameter int DWidth = 8,
  parameter int MEM_AW = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              active_i,
  input  logic [DWidth-1:0] len_i,
  input  logic [DWidth-1:0] omem_rdata_i,
  output logic              last_o,
  output logic              rd_en_o,
  output logic [MEM_AW-1:0] rd_addr_o,
  output logic              wr_en_o,
  output logic [MEM_AW-1:0] wr_addr_o,
  output logic [DWidth-1:0] wr_data_o
);

  logic [MEM_AW-1:0] cnt_q, cnt_d;
  logic [DWidth-1:0] len_q, len_d;
  logic              wr_en_q, wr_en_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [MEM_AW-1:0] last_idx;

  always_comb begin
    cnt_d     = cnt_q;
    len_d     = len_q;
    wr_en_d   = active_i;
    wr_addr_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
      len_d = len_i;
    end else if (active_i) begin
      cnt_d = cnt_q + MEM_AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      len_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign last_idx  = MEM_AW'(len_q) - MEM_AW'(1);
  assign last_o    = active_i && (cnt_q == last_idx);
  assign rd_en_o   = active_i;
  assign rd_addr_o = cnt_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  // OMEM returns data one cycle after the read, exactly when the write fires.
  assign wr_data_o = omem_rdata_i;

endmodule

// File: rtl/npu_cmd_dispatch.sv
// NPU command dispatcher: turns decoded host ops into registered memory strobes,
// OMEM/parameter reads, compute start handshakes and OMEM->IMEM moves.
module npu_cmd_dispatch
  import pkg_npu::*;
#(
  parameter int DWidth     = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 10,
  parameter int NUM_PARA   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cen_i,
  input  logic                       wen_i,
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  input  logic [DWidth-1:0]          wdata_i,
  input  logic [3:0]                 op_type_i,
  output logic                       imem_we_o,
  output logic                       wmem_we_o,
  output logic                       bmem_we_o,
  output logic [MEM_AW-1:0]          mem_waddr_o,
  output logic [DWidth-1:0]          mem_wdata_o,
  output logic                       omem_re_o,
  output logic [MEM_AW-1:0]          omem_raddr_o,
  input  logic [DWidth-1:0]          omem_rdata_i,
  output logic [DWidth-1:0]          rdata_o,
  output logic                       rvalid_o,
  output logic [NUM_PARA*DWidth-1:0] para_o,
  output logic                       compute_start_o,
  input  logic                       compute_done_i,
  output logic                       busy_o,
  output logic                       cmd_drop_o
);

  localparam int PIDX_W = $clog2(NUM_PARA);

  npu_op_e                              op;
  disp_state_e                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]                local_full;
  logic [MEM_AW-1:0]                    local_addr;
  logic                                 addr_hi_unused;
  logic                                 imem_we_q, imem_we_d, wmem_we_q, wmem_we_d, bmem_we_q, bmem_we_d;
  logic [MEM_AW-1:0]                    host_waddr_q, host_waddr_d, host_raddr_q, host_raddr_d;
  logic [DWidth-1:0]                    host_wdata_q, host_wdata_d, para_rdata_q, para_rdata_d;
  logic                                 host_re_q, host_re_d, rd_ret_q, rd_ret_d;
  logic                                 para_rvalid_q, para_rvalid_d;
  logic [NUM_PARA-1:0][DWidth-1:0]      para_q, para_d;
  logic                                 start_q, start_d, drop_q, drop_d, move_start;
  logic                                 mv_last, mv_rd_en, mv_wr_en;
  logic [MEM_AW-1:0]                    mv_rd_addr, mv_wr_addr;
  logic [DWidth-1:0]                    mv_wr_data;

  assign op             = npu_op_e'(op_type_i);
  assign local_full     = addr_i - ADDR_WIDTH'(region_base(op));
  assign local_addr     = local_full[MEM_AW-1:0];
  assign addr_hi_unused = ^local_full[ADDR_WIDTH-1:MEM_AW];

  always_comb begin
    state_d       = state_q;
    imem_we_d     = 1'b0;
    wmem_we_d     = 1'b0;
    bmem_we_d     = 1'b0;
    host_waddr_d  = host_waddr_q;
    host_wdata_d  = host_wdata_q;
    host_re_d     = 1'b0;
    host_raddr_d  = host_raddr_q;
    rd_ret_d      = host_re_q;
    para_rvalid_d = 1'b0;
    para_rdata_d  = para_rdata_q;
    para_d        = para_q;
    start_d       = 1'b0;
    move_start    = 1'b0;
    drop_d        = cen_i && (op != OP_NONE) && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (cen_i) begin
          case (op)
            OP_IMEM, OP_WMEM, OP_BMEM: begin
              if (wen_i) begin
                imem_we_d    = (op == OP_IMEM);
                wmem_we_d    = (op == OP_WMEM);
                bmem_we_d    = (op == OP_BMEM);
                host_waddr_d = local_addr;
                host_wdata_d = wdata_i;
              end
            end
            OP_OMEM: begin
              if (!wen_i) begin
                host_re_d    = 1'b1;
                host_raddr_d = local_addr;
              end
            end
            OP_PARA: begin
              // An OMEM read returning in the same cycle owns rdata_o; the para read is lost.
              if (wen_i) begin
                para_d[local_addr[PIDX_W-1:0]] = wdata_i;
              end else if (!host_re_q) begin
                para_rvalid_d = 1'b1;
                para_rdata_d  = para_q[local_addr[PIDX_W-1:0]];
              end
            end
            OP_OS_START: begin
              state_d = RUN;
              start_d = 1'b1;
            end
            OP_MOVE: begin
              if (wdata_i != '0) begin
                state_d    = MOVE;
                move_start = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      RUN:     if (compute_done_i) state_d = IDLE;
      MOVE:    if (mv_last) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      imem_we_q     <= 1'b0;
      wmem_we_q     <= 1'b0;
      bmem_we_q     <= 1'b0;
      host_waddr_q  <= '0;
      host_wdata_q  <= '0;
      host_re_q     <= 1'b0;
      host_raddr_q  <= '0;
      rd_ret_q      <= 1'b0;
      para_rvalid_q <= 1'b0;
      para_rdata_q  <= '0;
      para_q        <= '0;
      start_q       <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_we_q     <= imem_we_d;
      wmem_we_q     <= wmem_we_d;
      bmem_we_q     <= bmem_we_d;
      host_waddr_q  <= host_waddr_d;
      host_wdata_q  <= host_wdata_d;
      host_re_q     <= host_re_d;
      host_raddr_q  <= host_raddr_d;
      rd_ret_q      <= rd_ret_d;
      para_rvalid_q <= para_rvalid_d;
      para_rdata_q  <= para_rdata_d;
      para_q        <= para_d;
      start_q       <= start_d;
      drop_q        <= drop_d;
    end
  end

  npu_move_engine #(
    .DWidth (DWidth),
    .MEM_AW (MEM_AW)
  ) u_move_engine (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (move_start),
    .active_i     (state_q == MOVE),
    .len_i        (wdata_i),
    .omem_rdata_i (omem_rdata_i),
    .last_o       (mv_last),
    .rd_en_o      (mv_rd_en),
    .rd_addr_o    (mv_rd_addr),
    .wr_en_o      (mv_wr_en),
    .wr_addr_o    (mv_wr_addr),
    .wr_data_o    (mv_wr_data)
  );

  // Host and move traffic never overlap: host ops are only taken in IDLE.
  assign imem_we_o       = imem_we_q | mv_wr_en;
  assign wmem_we_o       = wmem_we_q;
  assign bmem_we_o       = bmem_we_q;
  assign mem_waddr_o     = mv_wr_en ? mv_wr_addr : host_waddr_q;
  assign mem_wdata_o     = mv_wr_en ? mv_wr_data : host_wdata_q;
  assign omem_re_o       = host_re_q | mv_rd_en;
  assign omem_raddr_o    = mv_rd_en ? mv_rd_addr : host_raddr_q;
  assign rvalid_o        = rd_ret_q | para_rvalid_q;
  assign rdata_o         = rd_ret_q ? omem_rdata_i : para_rdata_q;
  assign para_o          = para_q;
  assign compute_start_o = start_q;
  assign busy_o          = (state_q != IDLE);
  assign cmd_drop_o      = drop_q;

endmodule
